iadder_vl_b16_4b: RTL and testbench

Variable-latency 16-bit adder wrapping the 4-bit-window speculative-carry approximate adder. Each accepted operand pair produces the approximate sum plus a per-segment error mask one cycle later; when exact mode is requested and any segment mis-speculated, a correction cycle substitutes the exact sum. Sits between the operand source and consumers that switch per operation between approximate and exact arithmetic. Also keeps operation and error statistics.

---
 rtl/iadder_pkg.sv | 14 +
 rtl/iadder_spec_B16.sv | 30 +++
 rtl/iadder_vl_b16_4b.sv | 125 ++++++++++++
 tb/tb_iadder_vl_b16_4b.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iadder_pkg.sv
// rtl/iadder_pkg.sv - shared constants and state type for the variable-latency 16-bit adder
package iadder_pkg;
    localparam int DATA_W    = 16;
    localparam int N_SEG     = 6;
    localparam int WIN_W     = 4;
    localparam int SEG_OUT_W = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIX  = 2'd1,
        ST_RES  = 2'd2
    } state_t;
endpackage

// File: rtl/iadder_spec_B16.sv
// rtl/iadder_spec_B16.sv - 4-bit-window speculative-carry approximate adder with segment error mask
module iadder_spec_B16
    import iadder_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] approx_sum,
    output logic [N_SEG-1:0]  seg_err
);

    logic [DATA_W-1:0] ref_sum;
    logic [WIN_W:0]    win_sum;

    // Each window speculates its carry-in from operand A two bits below its base;
    // only the top two bits of each window are kept, compared against the true sum.
    always_comb begin
        ref_sum         = a + b;
        approx_sum      = '0;
        seg_err         = '0;
        win_sum         = '0;
        approx_sum[3:0] = a[3:0] + b[3:0];
        for (int k = 1; k <= N_SEG; k++) begin
            win_sum = {1'b0, a[2*k +: WIN_W]} + {1'b0, b[2*k +: WIN_W]}
                    + {{WIN_W{1'b0}}, a[2*k-2]};
            approx_sum[2*k+2 +: SEG_OUT_W] = win_sum[3:2];
            seg_err[k-1] = (win_sum[3:2] != ref_sum[2*k+2 +: SEG_OUT_W]);
        end
    end

endmodule

// File: rtl/iadder_vl_b16_4b.sv
// rtl/iadder_vl_b16_4b.sv - variable-latency adder: approximate result, optional exact correction, statistics
module iadder_vl_b16_4b
    import iadder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_exact,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_err,
    output logic              out_corr,
    output logic [N_SEG-1:0]  out_seg,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_ops,
    output logic [CNT_W-1:0]  stat_errs
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [N_SEG-1:0]  seg_q, seg_d;
    logic              corr_q, corr_d;
    logic [CNT_W-1:0]  ops_q, ops_d, errs_q, errs_d;

    logic [DATA_W-1:0] spec_sum;
    logic [N_SEG-1:0]  spec_seg;
    logic              spec_err;
    logic              accept;

    iadder_spec_B16 u_spec (
        .a          (in_a),
        .b          (in_b),
        .approx_sum (spec_sum),
        .seg_err    (spec_seg)
    );

    assign spec_err  = |spec_seg;
    // Ready depends only on state and consumer readiness, held low during reset.
    assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RES) && out_ready));
    assign accept    = in_valid && in_ready;

    assign out_valid = (state_q == ST_RES);
    assign out_sum   = sum_q;
    assign out_seg   = seg_q;
    assign out_err   = |seg_q;
    assign out_corr  = corr_q;
    assign stat_ops  = ops_q;
    assign stat_errs = errs_q;

    // Next-state, result register and saturating counter update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        seg_d   = seg_q;
        corr_d  = corr_q;
        ops_d   = ops_q;
        errs_d  = errs_q;

        case (state_q)
            ST_FIX: begin
                sum_d   = a_q + b_q;
                corr_d  = 1'b1;
                state_d = ST_RES;
            end
            ST_RES: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            sum_d   = spec_sum;
            seg_d   = spec_seg;
            corr_d  = 1'b0;
            state_d = (in_exact && spec_err) ? ST_FIX : ST_RES;
        end

        if (stat_clr) begin
            ops_d  = '0;
            errs_d = '0;
        end else if (accept) begin
            if (ops_q != {CNT_W{1'b1}}) begin
                ops_d = ops_q + 1'b1;
            end
            if (spec_err && (errs_q != {CNT_W{1'b1}})) begin
                errs_d = errs_q + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            seg_q   <= '0;
            corr_q  <= 1'b0;
            ops_q   <= '0;
            errs_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            seg_q   <= seg_d;
            corr_q  <= corr_d;
            ops_q   <= ops_d;
            errs_q  <= errs_d;
        end
    end

endmodule

// File: tb/tb_iadder_vl_b16_4b.sv
// tb/tb_iadder_vl_b16_4b.sv - table-driven bench for the variable-latency 16-bit adder
module tb_iadder_vl_b16_4b;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_exact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_err;
    logic        out_corr;
    logic [5:0]  out_seg;
    logic        stat_clr;
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ex;
        logic [15:0] sum;
        logic [5:0]  seg;
        logic        err;
        logic        corr;
    } vec_t;

    vec_t tbl[8];

    iadder_vl_b16_4b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_exact  (in_exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .out_corr  (out_corr),
        .out_seg   (out_seg),
        .stat_clr  (stat_clr),
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one table entry from IDLE and check result and latency.
    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        in_a     = tbl[i].a;
        in_b     = tbl[i].b;
        in_exact = tbl[i].ex;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, (tbl[i].ex && tbl[i].err) ? 32'd2 : 32'd1);
        check("sum", {16'd0, out_sum}, {16'd0, tbl[i].sum});
        check("seg", {26'd0, out_seg}, {26'd0, tbl[i].seg});
        check("err", {31'd0, out_err}, {31'd0, tbl[i].err});
        check("corr", {31'd0, out_corr}, {31'd0, tbl[i].corr});
    endtask

    initial begin
        logic [15:0] hold_sum;
        logic [15:0] hold_ops;

        tbl[0] = '{16'h000D, 16'h0002, 1'b0, 16'h001F, 6'b000001, 1'b1, 1'b0};
        tbl[1] = '{16'h000D, 16'h0002, 1'b1, 16'h000F, 6'b000001, 1'b1, 1'b1};
        tbl[2] = '{16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 6'b000000, 1'b0, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0000, 6'b000000, 1'b0, 1'b0};
        tbl[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 6'b000000, 1'b0, 1'b0};
        tbl[5] = '{16'h0800, 16'h0800, 1'b1, 16'h1000, 6'b000000, 1'b0, 1'b0};
        tbl[6] = '{16'h0001, 16'hFFFF, 1'b0, 16'hFFC0, 6'b111110, 1'b1, 1'b0};
        tbl[7] = '{16'h0001, 16'hFFFF, 1'b1, 16'h0000, 6'b111110, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0;
        out_ready = 1'b1; stat_clr = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_seg", {26'd0, out_seg}, 32'd0);
        check("rst_flags", {30'd0, out_err, out_corr}, 32'd0);
        check("rst_counters", {stat_ops, stat_errs}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end
        check("tbl_stat_ops", {16'd0, stat_ops}, 32'd8);
        check("tbl_stat_errs", {16'd0, stat_errs}, 32'd4);

        // Clear, then one correcting operation: exactly one error counted.
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        run_vec(1);
        check("one_err_errs", {16'd0, stat_errs}, 32'd1);
        check("one_err_ops", {16'd0, stat_ops}, 32'd1);

        // Back-to-back exact-mode ops with no error: no bubble.
        @(negedge clk);
        in_a = 16'h0000; in_b = 16'hFFFF; in_exact = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b_v0", {31'd0, out_valid}, 32'd1);
        check("b2b_s0", {16'd0, out_sum}, 32'h0000FFFF);
        check("b2b_rdy", {31'd0, in_ready}, 32'd1);
        in_a = 16'hFFFF; in_b = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_v1", {31'd0, out_valid}, 32'd1);
        check("b2b_s1", {16'd0, out_sum}, 32'h00000000);
        check("b2b_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);

        // Backpressure: result held, no accept while out_ready is low.
        out_ready = 1'b0;
        in_a = 16'h000D; in_b = 16'h0002; in_exact = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h1111;
        hold_sum = 16'h001F;
        hold_ops = stat_ops;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {16'd0, out_sum}, {16'd0, hold_sum});
            check("bp_flags", {24'd0, out_err, out_corr, out_seg}, {24'd0, 1'b1, 1'b0, 6'b000001});
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_ops", {16'd0, stat_ops}, {16'd0, hold_ops});
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {31'd0, out_valid}, 32'd0);

        // Reset during FIX discards the pending correction.
        in_a = 16'h000D; in_b = 16'h0002; in_exact = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("fix_no_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("fix_rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("fixrst_valid", {31'd0, out_valid}, 32'd0);
        check("fixrst_outs", {out_sum, 8'd0, out_err, out_corr, out_seg}, 32'd0);
        check("fixrst_cnt", {stat_ops, stat_errs}, 32'd0);
        @(negedge clk);
        check("fixrst_valid2", {31'd0, out_valid}, 32'd0);

        // Saturation: 65540 consecutive mis-speculating accepts.
        in_a = 16'h000D; in_b = 16'h0002; in_exact = 1'b0; in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_ops", {16'd0, stat_ops}, 32'h0000FFFF);
        check("sat_errs", {16'd0, stat_errs}, 32'h0000FFFF);

        // Clear coincident with an accept wins.
        stat_clr = 1'b1;
        check("clr_accepting", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        stat_clr = 1'b0;
        in_valid = 1'b0;
        check("clr_ops", {16'd0, stat_ops}, 32'd0);
        check("clr_errs", {16'd0, stat_errs}, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
